// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge_if
// Purpose  : Bundles the command port, response port and APB4 requester bus of
//            apb_master_bridge.
// Ports    : (interface signals)
//            cmd_*  - command handshake and payload (valid/ready)
//            rsp_*  - response handshake and payload (valid/ready)
//            busy   - bridge has work queued or in flight
//            p*     - APB4 bus (psel, penable, pwrite, paddr, pwdata, pstrb,
//                     pprot, prdata, pready, pslverr)
// Modports : master - the bridge's view; slave - the view of whatever
//            surrounds it (command source, response sink and APB completer).
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;
  logic [2:0]            cmd_prot;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  busy;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output busy,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  busy,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : APB4 requester. Commands are queued in a FIFO and executed one at
//            a time as SETUP/ACCESS transfers; each produces one response
//            (read data, error flag, timeout flag) held until consumed.
// Ports    : pclk     - APB clock, rising edge
//            preset_n - asynchronous active-low reset
//            bus      - apb_master_bridge_if.master (command, response, busy
//                       and APB signals)
// Params   : ADDR_WIDTH, DATA_WIDTH (8/16/32), FIFO_DEPTH (power of 2, >=2),
//            TIMEOUT_CYCLES (ACCESS cycles with pready low before abort,
//            0 disables the timeout)
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire logic             pclk,
  input  wire logic             preset_n,
  apb_master_bridge_if.master   bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
  localparam int c_TMO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? c_TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  // Command FIFO storage (no reset needed: validity is tracked by r_count)
  logic                  r_fifo_write [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_wdata [FIFO_DEPTH];
  logic [STRB_WIDTH-1:0] r_fifo_strb  [FIFO_DEPTH];
  logic [2:0]            r_fifo_prot  [FIFO_DEPTH];

  logic [c_PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_PTR_W:0]      r_count, w_count_nxt;
  logic                  r_cmd_ready;

  state_t                r_state, w_state_nxt;
  logic [c_TMO_W-1:0]    r_tmo_cnt;

  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [STRB_WIDTH-1:0] r_pstrb;
  logic [2:0]            r_pprot;

  logic                  r_rsp_valid, r_rsp_err, r_rsp_timeout;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic w_push, w_pop, w_done, w_abort, w_tmo_hit, w_psel, w_penable;

  assign w_push    = bus.cmd_valid && r_cmd_ready;
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == c_TMO_LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Launch only when the response slot is free (or freed this cycle)
        if ((r_count != '0) && (!r_rsp_valid || bus.rsp_ready)) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_psel      = 1'b1;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (bus.pready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FIFO level
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_fifo_write[r_wr_ptr] <= bus.cmd_write;
      r_fifo_addr [r_wr_ptr] <= bus.cmd_addr;
      r_fifo_wdata[r_wr_ptr] <= bus.cmd_wdata;
      r_fifo_strb [r_wr_ptr] <= bus.cmd_strb;
      r_fifo_prot [r_wr_ptr] <= bus.cmd_prot;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_cmd_ready   <= 1'b0;
      r_tmo_cnt     <= '0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_nxt;
      // Registered so that it is low throughout reset and rises one edge later
      r_cmd_ready <= (w_count_nxt != c_FULL);

      if (w_pop) begin
        r_pwrite <= r_fifo_write[r_rd_ptr];
        r_paddr  <= r_fifo_addr[r_rd_ptr];
        r_pwdata <= r_fifo_write[r_rd_ptr] ? r_fifo_wdata[r_rd_ptr] : '0;
        r_pstrb  <= r_fifo_write[r_rd_ptr] ? r_fifo_strb[r_rd_ptr]  : '0;
        r_pprot  <= r_fifo_prot[r_rd_ptr];
      end

      if (r_state == S_SETUP)
        r_tmo_cnt <= '0;
      else if ((r_state == S_ACCESS) && !bus.pready && !w_tmo_hit)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;

      // A completion reloads the response even if it is consumed this cycle
      if (w_done || w_abort) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_err     <= w_done ? bus.pslverr : 1'b1;
        r_rsp_timeout <= w_abort;
        r_rsp_rdata   <= (w_done && !r_pwrite) ? bus.prdata : '0;
      end else if (r_rsp_valid && bus.rsp_ready) begin
        r_rsp_valid   <= 1'b0;
        r_rsp_err     <= 1'b0;
        r_rsp_timeout <= 1'b0;
        r_rsp_rdata   <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.busy        = (r_state != S_IDLE) || (r_count != '0);
  assign bus.psel        = w_psel;
  assign bus.penable     = w_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.pstrb       = r_pstrb;
  assign bus.pprot       = r_pprot;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Self-checking bench for apb_master_bridge (DEPTH=4, TIMEOUT=8).
//            Table of single-command vectors plus sequences for FIFO fill /
//            ordering and asynchronous reset during ACCESS.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;
  localparam int AW = 32;
  localparam int DW = 32;

  logic pclk     = 1'b0;
  logic preset_n = 1'b0;
  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .bus     (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wait_n;     // wait cycles before pready; 255 = never
    logic        slverr;
    logic [31:0] prdata;
    int          exp_acc;    // expected number of ACCESS cycles
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_rdata;
    logic [31:0] exp_pwdata;
    logic [3:0]  exp_pstrb;
  } vec_t;

  vec_t vecs [6];

  task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot);
    int n;
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 50) check("cmd_accept_bound", 32'(n), 32'd0);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    int   acc;
    logic unstable;
    push_cmd(v.wr, v.addr, v.wdata, v.strb, v.prot);
    n = 0;
    while (!bus.psel && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check($sformatf("v%0d_latency", idx), 32'(n), 32'd1);
    check($sformatf("v%0d_setup_penable", idx), 32'(bus.penable), 32'd0);
    check($sformatf("v%0d_paddr", idx), bus.paddr, v.addr);
    check($sformatf("v%0d_pwrite", idx), 32'(bus.pwrite), 32'(v.wr));
    check($sformatf("v%0d_pwdata", idx), bus.pwdata, v.exp_pwdata);
    check($sformatf("v%0d_pstrb", idx), 32'(bus.pstrb), 32'(v.exp_pstrb));
    check($sformatf("v%0d_pprot", idx), 32'(bus.pprot), 32'(v.prot));
    bus.pslverr = v.slverr;
    bus.prdata  = v.prdata;
    bus.pready  = 1'b0;
    acc      = 0;
    unstable = 1'b0;
    @(negedge pclk);
    while (bus.penable && acc < 100) begin
      acc++;
      if (!bus.psel || bus.paddr !== v.addr || bus.pstrb !== v.exp_pstrb ||
          bus.pwdata !== v.exp_pwdata || bus.pprot !== v.prot)
        unstable = 1'b1;
      bus.pready = (acc == v.wait_n + 1);
      @(negedge pclk);
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    check($sformatf("v%0d_stable", idx), 32'(unstable), 32'd0);
    check($sformatf("v%0d_access_cycles", idx), 32'(acc), 32'(v.exp_acc));
    check($sformatf("v%0d_rsp_valid", idx), 32'(bus.rsp_valid), 32'd1);
    check($sformatf("v%0d_rsp_err", idx), 32'(bus.rsp_err), 32'(v.exp_err));
    check($sformatf("v%0d_rsp_timeout", idx), 32'(bus.rsp_timeout), 32'(v.exp_to));
    check($sformatf("v%0d_rsp_rdata", idx), bus.rsp_rdata, v.exp_rdata);
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_cleared", idx), 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int   n;
    int   acc;
    int   got;
    logic rdy;
    logic pend;
    logic psel_seen;

    //            wr    addr          wdata         strb  prot  wait slverr prdata       acc err   to    rdata         pwdata        pstrb
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 4'hF, 3'd0, 0,   1'b0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 32'h0,         32'hA5A5_0001, 4'hF};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3'd2, 3,   1'b0, 32'h1234_5678, 4, 1'b0, 1'b0, 32'h1234_5678, 32'h0,         4'h0};
    vecs[2] = '{1'b1, 32'h0000_0030, 32'h0000_BEEF, 4'h3, 3'd1, 0,   1'b1, 32'h5555_5555, 1, 1'b1, 1'b0, 32'h0,         32'h0000_BEEF, 4'h3};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h1111_1111, 4'hF, 3'd0, 255, 1'b0, 32'h7777_7777, 8, 1'b1, 1'b1, 32'h0,         32'h0,         4'h0};
    vecs[4] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 3'd4, 1,   1'b1, 32'hCAFE_F00D, 2, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0,         4'h0};
    vecs[5] = '{1'b1, 32'h0000_0048, 32'h0BAD_CAFE, 4'h5, 3'd7, 2,   1'b0, 32'h9999_9999, 3, 1'b0, 1'b0, 32'h0,         32'h0BAD_CAFE, 4'h5};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    // ---------------- reset state
    repeat (3) @(negedge pclk);
    check("rst_psel", 32'(bus.psel), 32'd0);
    check("rst_penable", 32'(bus.penable), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_paddr", bus.paddr, 32'h0);
    preset_n = 1'b1;
    check("rel_cmd_ready_before_edge", 32'(bus.cmd_ready), 32'd0);
    @(negedge pclk);
    check("rel_cmd_ready_after_edge", 32'(bus.cmd_ready), 32'd1);

    // ---------------- table-driven single commands
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // ---------------- FIFO fill with held response, then ordered drain
    bus.pready = 1'b1;
    push_cmd(1'b0, 32'h100, 32'h0, 4'h0, 3'd0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      bus.prdata = bus.paddr + 32'h1000_0000;
      @(negedge pclk);
      n++;
    end
    check("fill_first_rsp", bus.rsp_rdata, 32'h1000_0100);

    acc       = 0;
    psel_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.cmd_valid = (acc < 5);
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h104 + 32'(4 * acc);
      rdy = bus.cmd_ready;
      @(negedge pclk);
      if (rdy && acc < 5) acc++;
      if (bus.psel) psel_seen = 1'b1;
    end
    check("fill_accepted", 32'(acc), 32'd4);
    check("fill_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    check("fill_no_transfer", 32'(psel_seen), 32'd0);
    check("fill_rsp_held", 32'(bus.rsp_valid), 32'd1);

    bus.rsp_ready = 1'b1;
    got  = 0;
    pend = 1'b0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      bus.prdata = bus.paddr + 32'h1000_0000;
      if (bus.rsp_valid) begin
        check($sformatf("order%0d", got), bus.rsp_rdata, 32'h1000_0100 + 32'(4 * got));
        got++;
      end
      if (pend) begin
        bus.cmd_valid = 1'b0;
        pend = 1'b0;
      end else if (bus.cmd_valid && bus.cmd_ready) begin
        pend = 1'b1;
      end
      @(negedge pclk);
    end
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    check("drain_count", 32'(got), 32'd6);

    // ---------------- asynchronous reset during ACCESS
    push_cmd(1'b1, 32'h200, 32'h1, 4'hF, 3'd0);
    push_cmd(1'b1, 32'h204, 32'h2, 4'hF, 3'd0);
    n = 0;
    while (!bus.penable && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("arst_in_access", 32'(bus.penable), 32'd1);
    #2;
    preset_n = 1'b0;
    #1;
    check("arst_psel", 32'(bus.psel), 32'd0);
    check("arst_penable", 32'(bus.penable), 32'd0);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge pclk);
    preset_n = 1'b1;
    repeat (3) @(negedge pclk);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_psel", 32'(bus.psel), 32'd0);
    check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    run_vec(vecs[1], 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
